// File: rtl/rv_decode_queue.sv
// Fetch-to-decode buffer: a circular FIFO of {pc, instr} feeding one registered
// decode stage that presents the raw word, register fields and class flags.
module rv_decode_queue #(
    parameter int DEPTH = 4,
    parameter bit RV32M = 1'b1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic          f_valid_i,
    input  logic [31:0]   f_instr_i,
    input  logic [31:0]   f_pc_i,
    output logic          f_ready_o,
    input  logic          flush_i,
    output logic          d_valid_o,
    input  logic          d_ready_i,
    output logic [31:0]   d_pc_o,
    output logic [31:0]   d_instr_o,
    output logic [4:0]    d_rs1_addr_o,
    output logic [4:0]    d_rs2_addr_o,
    output logic [4:0]    d_rd_addr_o,
    output logic          d_rs1_re_o,
    output logic          d_rs2_re_o,
    output logic          d_wb_we_o,
    output logic          d_mem_req_o,
    output logic          d_mem_we_o,
    output logic          d_mdu_req_o,
    output logic          d_branch_o,
    output logic          d_jal_o,
    output logic          d_jalr_o,
    output logic          d_fence_o,
    output logic          d_illegal_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          d_valid_r;
    logic [31:0]   d_pc_r, d_instr_r;
    logic [10:0]   d_flags_r;

    logic          accept_s, stage_free_s, push_s, pop_s, bypass_s, stage_load_s;
    logic [63:0]   st_word_s;
    logic [4:0]    opc_s;
    logic [2:0]    f3_s;
    logic [6:0]    f7_s;
    logic          is_lui_s, is_auipc_s, is_jal_s, is_jalr_s, is_br_s, is_ld_s;
    logic          is_st_s, is_opi_s, is_op_s, is_mm_s, legal_opc_s, ill_s;
    logic [10:0]   dec_s;

    assign f_ready_o = (count_r < CW'(DEPTH)) && !flush_i;

    // Handshake and stage-source selection; the FIFO head always has priority over bypass.
    always_comb begin
        accept_s     = f_valid_i && f_ready_o;
        stage_free_s = !d_valid_r || d_ready_i;
        pop_s        = 1'b0;
        bypass_s     = 1'b0;
        stage_load_s = 1'b0;
        if (stage_free_s && (count_r != '0)) begin
            pop_s        = 1'b1;
            stage_load_s = 1'b1;
        end else if (stage_free_s && accept_s) begin
            bypass_s     = 1'b1;
            stage_load_s = 1'b1;
        end else begin
            stage_load_s = 1'b0;
        end
        push_s = accept_s && !bypass_s;
        if (pop_s) begin
            st_word_s = mem_r[rd_ptr_r];
        end else begin
            st_word_s = {f_pc_i, f_instr_i};
        end
    end

    // Decode of the word about to enter the stage; flags order is
    // {illegal, rs1_re, rs2_re, wb_we, mem_req, mem_we, mdu, branch, jal, jalr, fence}.
    always_comb begin
        opc_s       = st_word_s[6:2];
        f3_s        = st_word_s[14:12];
        f7_s        = st_word_s[31:25];
        is_lui_s    = 1'b0;
        is_auipc_s  = 1'b0;
        is_jal_s    = 1'b0;
        is_jalr_s   = 1'b0;
        is_br_s     = 1'b0;
        is_ld_s     = 1'b0;
        is_st_s     = 1'b0;
        is_opi_s    = 1'b0;
        is_op_s     = 1'b0;
        is_mm_s     = 1'b0;
        legal_opc_s = 1'b1;
        case (opc_s)
            5'b01101: is_lui_s   = 1'b1;
            5'b00101: is_auipc_s = 1'b1;
            5'b11011: is_jal_s   = 1'b1;
            5'b11001: is_jalr_s  = 1'b1;
            5'b11000: is_br_s    = 1'b1;
            5'b00000: is_ld_s    = 1'b1;
            5'b01000: is_st_s    = 1'b1;
            5'b00100: is_opi_s   = 1'b1;
            5'b01100: is_op_s    = 1'b1;
            5'b00011: is_mm_s    = 1'b1;
            default:  legal_opc_s = 1'b0;
        endcase
        ill_s = (st_word_s[1:0] != 2'b11) || !legal_opc_s
            || ((is_jalr_s || is_mm_s) && (f3_s != 3'd0))
            || (is_ld_s && ((f3_s == 3'd3) || (f3_s == 3'd6) || (f3_s == 3'd7)))
            || (is_st_s && (f3_s > 3'd2))
            || (is_br_s && ((f3_s == 3'd2) || (f3_s == 3'd3)))
            || (is_op_s && !((f7_s == 7'h00) || (f7_s == 7'h20) || (f7_s == 7'h01)))
            || (is_op_s && (f7_s == 7'h20) && !((f3_s == 3'd0) || (f3_s == 3'd5)))
            || (is_op_s && (f7_s == 7'h01) && !RV32M)
            || (is_opi_s && (f3_s == 3'd1) && (f7_s != 7'h00))
            || (is_opi_s && (f3_s == 3'd5) && (f7_s != 7'h00) && (f7_s != 7'h20));
        if (ill_s) begin
            dec_s = 11'b100_0000_0000;
        end else begin
            dec_s = {1'b0,
                     !(is_lui_s || is_auipc_s || is_jal_s || is_mm_s),
                     is_op_s || is_br_s || is_st_s,
                     !(is_br_s || is_st_s || is_mm_s),
                     is_ld_s || is_st_s,
                     is_st_s,
                     is_op_s && (f7_s == 7'h01),
                     is_br_s, is_jal_s, is_jalr_s, is_mm_s};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 64'h0;
        end else if (!flush_i && push_s) begin
            mem_r[wr_ptr_r] <= {f_pc_i, f_instr_i};
        end
    end

    // Output stage; data and flags only change on a load so they hold under backpressure.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            d_valid_r <= 1'b0;
            d_pc_r    <= 32'h0;
            d_instr_r <= 32'h0;
            d_flags_r <= 11'h0;
        end else if (flush_i) begin
            d_valid_r <= 1'b0;
        end else if (stage_load_s) begin
            d_valid_r <= 1'b1;
            d_pc_r    <= st_word_s[63:32];
            d_instr_r <= st_word_s[31:0];
            d_flags_r <= dec_s;
        end else if (stage_free_s) begin
            d_valid_r <= 1'b0;
        end
    end

    assign d_valid_o    = d_valid_r;
    assign d_pc_o       = d_pc_r;
    assign d_instr_o    = d_instr_r;
    assign d_rs1_addr_o = d_instr_r[19:15];
    assign d_rs2_addr_o = d_instr_r[24:20];
    assign d_rd_addr_o  = d_instr_r[11:7];
    assign {d_illegal_o, d_rs1_re_o, d_rs2_re_o, d_wb_we_o, d_mem_req_o, d_mem_we_o,
            d_mdu_req_o, d_branch_o, d_jal_o, d_jalr_o, d_fence_o} = d_flags_r;
    assign count_o      = count_r;

endmodule

// File: tb/tb_rv_decode_queue.sv
// Bench for rv_decode_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rv_decode_queue;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk_i = 1'b0;
    logic arstn_i = 1'b0;
    logic f_valid_i = 1'b0, flush_i = 1'b0, d_ready_i = 1'b0;
    logic [31:0] f_instr_i = 32'h0, f_pc_i = 32'h0;

    wire f_ready_o, d_valid_o, f_ready_n, d_valid_n;
    wire [31:0] d_pc_o, d_instr_o, d_pc_n, d_instr_n;
    wire [4:0] rs1_o, rs2_o, rd_o, rs1_n, rs2_n, rd_n;
    wire [10:0] fl_m, fl_n;
    wire [CW-1:0] count_o, count_n;

    always #5 clk_i = ~clk_i;

    rv_decode_queue #(.DEPTH(DEPTH), .RV32M(1'b1)) u_dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .f_valid_i(f_valid_i), .f_instr_i(f_instr_i),
        .f_pc_i(f_pc_i), .f_ready_o(f_ready_o), .flush_i(flush_i), .d_valid_o(d_valid_o),
        .d_ready_i(d_ready_i), .d_pc_o(d_pc_o), .d_instr_o(d_instr_o),
        .d_rs1_addr_o(rs1_o), .d_rs2_addr_o(rs2_o), .d_rd_addr_o(rd_o),
        .d_rs1_re_o(fl_m[9]), .d_rs2_re_o(fl_m[8]), .d_wb_we_o(fl_m[7]),
        .d_mem_req_o(fl_m[6]), .d_mem_we_o(fl_m[5]), .d_mdu_req_o(fl_m[4]),
        .d_branch_o(fl_m[3]), .d_jal_o(fl_m[2]), .d_jalr_o(fl_m[1]), .d_fence_o(fl_m[0]),
        .d_illegal_o(fl_m[10]), .count_o(count_o));

    rv_decode_queue #(.DEPTH(DEPTH), .RV32M(1'b0)) u_dut_nom (
        .clk_i(clk_i), .arstn_i(arstn_i), .f_valid_i(f_valid_i), .f_instr_i(f_instr_i),
        .f_pc_i(f_pc_i), .f_ready_o(f_ready_n), .flush_i(flush_i), .d_valid_o(d_valid_n),
        .d_ready_i(d_ready_i), .d_pc_o(d_pc_n), .d_instr_o(d_instr_n),
        .d_rs1_addr_o(rs1_n), .d_rs2_addr_o(rs2_n), .d_rd_addr_o(rd_n),
        .d_rs1_re_o(fl_n[9]), .d_rs2_re_o(fl_n[8]), .d_wb_we_o(fl_n[7]),
        .d_mem_req_o(fl_n[6]), .d_mem_we_o(fl_n[5]), .d_mdu_req_o(fl_n[4]),
        .d_branch_o(fl_n[3]), .d_jal_o(fl_n[2]), .d_jalr_o(fl_n[1]), .d_fence_o(fl_n[0]),
        .d_illegal_o(fl_n[10]), .count_o(count_n));

    int tests_run = 0;
    int tests_failed = 0;
    logic [63:0] m_q[$];
    bit m_v = 1'b0;
    logic [63:0] m_w = 64'h0;
    logic last_rdy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected flags {illegal, rs1_re, rs2_re, wb_we, mem_req, mem_we, mdu, branch, jal, jalr, fence}.
    function automatic logic [10:0] ref_dec(input logic [31:0] w, input bit m);
        logic [4:0] op = w[6:2];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        bit lui = (op == 5'h0D), auipc = (op == 5'h05), jal = (op == 5'h1B);
        bit jalr = (op == 5'h19), br = (op == 5'h18), ld = (op == 5'h00);
        bit st = (op == 5'h08), opi = (op == 5'h04), opr = (op == 5'h0C), mm = (op == 5'h03);
        bit legal = (w[1:0] == 2'b11) && (lui || auipc || jal || jalr || br || ld || st || opi || opr || mm);
        if ((jalr || mm) && f3 != 3'd0) legal = 1'b0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) legal = 1'b0;
        if (st && f3 > 3'd2) legal = 1'b0;
        if (br && (f3 inside {3'd2, 3'd3})) legal = 1'b0;
        if (opr && !((f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) || (f7 == 7'h01 && m)))
            legal = 1'b0;
        if (opi && f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
        if (opi && f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) legal = 1'b0;
        if (!legal) return 11'b100_0000_0000;
        return {1'b0, !(lui || auipc || jal || mm), opr || br || st, !(br || st || mm),
                ld || st, st, opr && (f7 == 7'h01), br, jal, jalr, mm};
    endfunction

    task automatic model_check();
        if (!arstn_i) begin
            chk("rst_valid", {63'h0, d_valid_o}, 64'h0);
            chk("rst_count", {{(64-CW){1'b0}}, count_o}, 64'h0);
            chk("rst_data", {d_pc_o, d_instr_o}, 64'h0);
            chk("rst_flags", {53'h0, fl_m}, 64'h0);
            chk("rst_ready", {63'h0, f_ready_o}, {63'h0, !flush_i});
        end else begin
            chk("valid", {63'h0, d_valid_o}, {63'h0, m_v});
            chk("valid_nom", {63'h0, d_valid_n}, {63'h0, m_v});
            chk("count", {{(64-CW){1'b0}}, count_o}, 64'(m_q.size()));
            chk("f_ready", {63'h0, f_ready_o}, {63'h0, (m_q.size() < DEPTH) && !flush_i});
            if (m_v) begin
                chk("pc_instr", {d_pc_o, d_instr_o}, m_w);
                chk("reg_fields", {49'h0, rs1_o, rs2_o, rd_o}, {49'h0, m_w[19:15], m_w[24:20], m_w[11:7]});
                chk("flags", {53'h0, fl_m}, {53'h0, ref_dec(m_w[31:0], 1'b1)});
                chk("flags_nom", {53'h0, fl_n}, {53'h0, ref_dec(m_w[31:0], 1'b0)});
            end
        end
    endtask

    task automatic model_update();
        bit acc, byp;
        if (!arstn_i || flush_i) begin
            m_q.delete();
            m_v = 1'b0;
        end else begin
            acc = f_valid_i && (m_q.size() < DEPTH);
            byp = 1'b0;
            if (!m_v || d_ready_i) begin
                if (m_q.size() > 0) begin
                    m_w = m_q.pop_front();
                    m_v = 1'b1;
                end else if (acc) begin
                    m_w = {f_pc_i, f_instr_i};
                    m_v = 1'b1;
                    byp = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
            end
            if (acc && !byp) m_q.push_back({f_pc_i, f_instr_i});
        end
    endtask

    // One cycle: drive, check against model mid-cycle, advance model with the edge.
    task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic dr, input logic fl);
        f_valid_i = fv; f_instr_i = ins; f_pc_i = pc; d_ready_i = dr; flush_i = fl;
        @(negedge clk_i);
        model_check();
        last_rdy = f_ready_o;
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    logic [31:0] pool [20] = '{32'h00500093, 32'h02208033, 32'h0220C0B3, 32'h40000033,
                               32'h40001033, 32'h0000A003, 32'h0000B003, 32'h0020A023,
                               32'h0020B023, 32'h00208063, 32'h0020A063, 32'h008000EF,
                               32'h000080E7, 32'h000090E7, 32'h000010B7, 32'h00001097,
                               32'h0FF0000F, 32'h0000100F, 32'h02009093, 32'h4000D093};

    initial begin
        int k, n;
        logic [31:0] w, got [6];

        chk("ref_addi", {53'h0, ref_dec(32'h00500093, 1'b1)}, {53'h0, 11'b010_1000_0000});
        chk("ref_sw", {53'h0, ref_dec(32'h0020A023, 1'b1)}, {53'h0, 11'b011_0110_0000});
        chk("ref_mul_nom", {53'h0, ref_dec(32'h02208033, 1'b0)}, {53'h0, 11'b100_0000_0000});

        repeat (3) step(1'b1, 32'h00500093, 32'h40, 1'b1, 1'b0);
        chk("rst_d_valid", {63'h0, d_valid_o}, 64'h0);
        chk("rst_d_instr", {32'h0, d_instr_o}, 64'h0);
        arstn_i = 1'b1;
        #1;
        chk("ready_after_rst", {63'h0, f_ready_o}, 64'h1);

        // addi x1,x0,5 through an empty queue
        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        chk("addi_valid", {63'h0, d_valid_o}, 64'h1);
        chk("addi_rd", {59'h0, rd_o}, 64'h1);
        chk("addi_flags", {60'h0, fl_m[10], fl_m[9], fl_m[8], fl_m[7]}, {60'h0, 4'b0101});
        chk("addi_count", {{(64-CW){1'b0}}, count_o}, 64'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // fill under backpressure, then drain in order
        k = 0;
        for (int c = 0; c < 12; c++) begin
            w = 32'h00000093 | (32'(k) << 20) | (32'(k + 1) << 7);
            step(1'b1, w, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
            if (last_rdy) k++;
        end
        chk("fill_accepted", 64'(k), 64'd5);
        chk("fill_count", {{(64-CW){1'b0}}, count_o}, 64'd4);
        chk("fill_ready", {63'h0, f_ready_o}, 64'h0);
        chk("fill_stage_pc", {32'h0, d_pc_o}, 64'h200);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (d_valid_o && n < 6) begin got[n] = d_pc_o; n++; end
            w = 32'h00000093 | (32'(k) << 20) | (32'(k + 1) << 7);
            step(k < 6, w, 32'h200 + 32'(4 * k), 1'b1, 1'b0);
            if (last_rdy && k < 6) k++;
        end
        chk("drain_n", 64'(n), 64'd6);
        for (int i = 0; i < 6; i++) chk("drain_order", {32'h0, got[i]}, 64'h200 + 64'(4 * i));

        // mul with and without M extension
        step(1'b1, 32'h02208033, 32'h300, 1'b1, 1'b0);
        chk("mul_m", {62'h0, fl_m[10], fl_m[4]}, {62'h0, 2'b01});
        chk("mul_nom", {61'h0, fl_n[10], fl_n[4], fl_n[7]}, {61'h0, 3'b100});

        step(1'b1, 32'h0000A003, 32'h304, 1'b1, 1'b0);
        chk("lw_ok", {62'h0, fl_m[10], fl_m[6]}, {62'h0, 2'b01});
        step(1'b1, 32'h0000B003, 32'h308, 1'b1, 1'b0);
        chk("ld_f3_3", {62'h0, fl_m[10], fl_m[6]}, {62'h0, 2'b10});
        step(1'b1, 32'h00000000, 32'h30C, 1'b1, 1'b0);
        chk("zero_word", {63'h0, fl_m[10]}, 64'h1);
        chk("zero_pc", {32'h0, d_pc_o}, 64'h30C);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // flush with three buffered words and a concurrent fetch
        for (int i = 0; i < 4; i++) step(1'b1, 32'h00100093, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
        chk("pre_flush_count", {{(64-CW){1'b0}}, count_o}, 64'd3);
        chk("pre_flush_valid", {63'h0, d_valid_o}, 64'h1);
        step(1'b1, 32'h00200093, 32'h500, 1'b0, 1'b1);
        chk("flush_count", {{(64-CW){1'b0}}, count_o}, 64'h0);
        chk("flush_valid", {63'h0, d_valid_o}, 64'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_not_stored", {63'h0, d_valid_o}, 64'h0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int idx = $urandom_range(0, 25);
            if (idx < 20) w = pool[idx];
            else if (idx < 24) w = {$urandom()} | 32'h3;
            else w = $urandom();
            step($urandom_range(0, 3) != 0, w, $urandom(),
                 (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 49) == 0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00300093, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
        chk("pre_rst_count", {{(64-CW){1'b0}}, count_o}, 64'd2);
        arstn_i = 1'b0;
        #1;
        chk("arst_valid", {63'h0, d_valid_o}, 64'h0);
        chk("arst_count", {{(64-CW){1'b0}}, count_o}, 64'h0);
        chk("arst_data", {d_pc_o, d_instr_o}, 64'h0);
        chk("arst_flags", {53'h0, fl_m}, 64'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        arstn_i = 1'b1;
        step(1'b1, 32'h00700093, 32'h700, 1'b1, 1'b0);
        chk("post_rst_valid", {63'h0, d_valid_o}, 64'h1);
        chk("post_rst_pc", {32'h0, d_pc_o}, 64'h700);
        chk("post_rst_count", {{(64-CW){1'b0}}, count_o}, 64'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv_decode_queue.md
RV_DECODE_QUEUE -- requirements
Module: rv_decode_queue

Interface
REQ-001 Parameters: DEPTH, default 4, FIFO entries (power of 2, 2..16); RV32M, default 1, enables M-extension decode; CW = $clog2(DEPTH+1).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 arstn_i  input  1  reset, asynchronous, active-low.
REQ-004 f_valid_i  input  1  fetch offers instruction.
REQ-005 f_instr_i  input  32  instruction word.
REQ-006 f_pc_i  input  32  instruction address.
REQ-007 f_ready_o  output  1  queue accepts fetch word.
REQ-008 flush_i  input  1  discard all buffered and staged instructions.
REQ-009 d_valid_o  output  1  decoded instruction staged.
REQ-010 d_ready_i  input  1  execute consumes staged instruction.
REQ-011 d_pc_o, d_instr_o  output  32 each  staged PC and raw word.
REQ-012 d_rs1_addr_o, d_rs2_addr_o, d_rd_addr_o  output  5 each  instr[19:15], [24:20], [11:7].
REQ-013 d_rs1_re_o, d_rs2_re_o, d_wb_we_o, d_mem_req_o, d_mem_we_o, d_mdu_req_o, d_branch_o, d_jal_o, d_jalr_o, d_fence_o  output  1 each  decoded class flags.
REQ-014 d_illegal_o  output  1  staged word is illegal.
REQ-015 count_o  output  CW  FIFO occupancy, excluding output stage.

Function
REQ-016 Structure: DEPTH-entry circular FIFO of {pc, instr} feeding one output register stage holding {pc, instr, decoded flags}.
REQ-017 Fetch handshake: transfer when f_valid_i && f_ready_o; f_ready_o = (count_o < DEPTH) && !flush_i, never dependent on d_ready_i.
REQ-018 Stage load: output stage is free when !d_valid_o or (d_valid_o && d_ready_i); when free, it loads FIFO head if count_o > 0, else the incoming fetch word (bypass), else clears d_valid_o.
REQ-019 Latency: word accepted at edge N with empty FIFO and free stage appears with d_valid_o=1 after edge N (one cycle); otherwise it is written to FIFO tail.
REQ-020 Ordering strictly FIFO; bypass only when count_o == 0.
REQ-021 Simultaneous FIFO push and pop: count_o unchanged, both pointers advance.
REQ-022 Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 without special handling.
REQ-023 d_* outputs hold stable while d_valid_o && !d_ready_i.
REQ-024 Decode (registered at stage load) from opcode instr[6:2], funct3 [14:12], funct7 [31:25]; legal opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM.
REQ-025 Illegal when: instr[1:0] != 2'b11; opcode not legal; JALR/FENCE funct3 != 0; LOAD funct3 in {3,6,7}; STORE funct3 > 2; BRANCH funct3 in {2,3}; OP funct7 not in {0x00,0x20,0x01}; OP funct7=0x20 with funct3 not in {0,5}; OP funct7=0x01 with RV32M=0; OP-IMM shift with invalid funct7.
REQ-026 When d_illegal_o=1, all class flags and rs/wb enables are 0; d_pc_o/d_instr_o still valid.
REQ-027 d_rs1_re_o for all legal opcodes except LUI, AUIPC, JAL, FENCE; d_rs2_re_o for OP, BRANCH, STORE; d_wb_we_o for legal except BRANCH, STORE, FENCE; d_mdu_req_o for legal OP with funct7=0x01.
REQ-028 flush_i: at next edge FIFO emptied (pointers to 0, count_o=0), d_valid_o=0; fetch input ignored in flush cycle; flush overrides simultaneous push and stage load.
REQ-029 Full: count_o == DEPTH forces f_ready_o=0; a pop in the same cycle does not re-enable ready until next cycle.

Reset
REQ-030 arstn_i low asynchronously: pointers 0, count_o=0, d_valid_o=0, all d_* data/flag outputs 0; f_ready_o=1 after release.
REQ-031 Reset mid-operation discards all buffered words; no partial state survives.

Verification
REQ-032 Empty queue, push 0x00500093 (addi x1,x0,5) at PC 0x100, d_ready_i=1 -> next cycle d_valid_o=1, d_rd_addr_o=1, d_wb_we_o=1, d_rs1_re_o=1, d_rs2_re_o=0, count_o=0.
REQ-033 d_ready_i=0, DEPTH=4, push 6 words -> stage holds word0, count_o=4, f_ready_o=0, word5 stalled; release d_ready_i -> words emerge in order 0..5, pointers wrap.
REQ-034 Push 0x02208033 (mul) with RV32M=0 -> d_illegal_o=1, d_mdu_req_o=0, d_wb_we_o=0; with RV32M=1 -> d_mdu_req_o=1, d_illegal_o=0.
REQ-035 Push 0x0000A003 (load funct3=2 ok) then 0x0000B003 (funct3=3) -> second d_illegal_o=1, d_mem_req_o=0; 0x00000000 -> d_illegal_o=1.
REQ-036 Count_o=3 with d_valid_o=1, assert flush_i concurrently with f_valid_i -> next cycle count_o=0, d_valid_o=0, flushed-cycle word not stored.
REQ-037 Drop arstn_i mid-burst with count_o=2 -> outputs zero immediately; after release, first push appears one cycle later.
